axi_id_compress: RTL and testbench
==================================

AXI_ID_COMPRESS -- requirements
Module: axi_id_compress

Interface
REQ-001 SHALL have parameter SlvPortIdWidth, default 6: ID width at slave port.
REQ-002 SHALL have parameter MstPortIdWidth, default 2: ID width at master port; SlvPortIdWidth > MstPortIdWidth.
REQ-003 SHALL have parameter MaxUniqIds, default 4: table entries per direction; 1 <= MaxUniqIds <= 2**MstPortIdWidth.
REQ-004 SHALL have parameter MaxTxnsPerId, default 2: max in-flight transactions per table entry, >= 1.
REQ-005 SHALL have type parameters slv_req_t, slv_resp_t, mst_req_t, mst_resp_t, default logic: AXI4 request/response structs per port ID width.
REQ-006 SHALL have port clk_i  input  1  rising-edge clock of all channels.
REQ-007 SHALL have port rst_ni  input  1  asynchronous reset, active low.
REQ-008 SHALL have port slv_req_i  input  slv_req_t  upstream AXI request.
REQ-009 SHALL have port slv_resp_o  output  slv_resp_t  upstream AXI response.
REQ-010 SHALL have port mst_req_o  output  mst_req_t  downstream AXI request, compressed IDs.
REQ-011 SHALL have port mst_resp_i  input  mst_resp_t  downstream AXI response.

Function
REQ-012 SHALL keep two independent tables, write (AW/B) and read (AR/R); each entry holds valid bit, original ID, counter of $clog2(MaxTxnsPerId+1) bits.
REQ-013 On AW/AR, SHALL select a matching valid entry with counter < MaxTxnsPerId; else, if no valid entry matches, the lowest-index invalid entry; else stall.
REQ-014 SHALL stall (no match-entry capacity, or no free entry) by holding mst valid and slv ready low for that channel; a matching entry at MaxTxnsPerId always stalls, never allocates a second entry for the same ID.
REQ-015 SHALL drive mst aw.id / ar.id as the selected index, zero-extended to MstPortIdWidth; all other AW/AR fields pass unchanged except aw.atop forced to '0 (ATOPs unsupported).
REQ-016 SHALL be combinational on all channels (zero latency); valid/ready coupling: mst valid = slv valid AND NOT stall, slv ready = mst ready AND NOT stall.
REQ-017 SHALL update table (set valid, store ID, counter +1) on the clock edge of the mst-side AW/AR handshake only.
REQ-018 SHALL pass W channel unchanged in both directions.
REQ-019 SHALL restore slv b.id / r.id from the entry indexed by the returned ID; all other B/R fields pass unchanged.
REQ-020 SHALL decrement the entry counter on each B handshake and on each R handshake with r.last=1; entry becomes invalid when counter reaches 0 in that cycle.
REQ-021 Same-cycle increment and decrement on one entry SHALL leave counter unchanged and entry valid.
REQ-022 A returned B/R whose index addresses an invalid entry SHALL pass with slv id '0 and SHALL NOT modify the table.
REQ-023 Freed entry SHALL be allocatable in the cycle after the freeing handshake, not the same cycle.

Reset
REQ-024 On rst_ni low, asynchronously SHALL clear all valid bits and counters in both tables.
REQ-025 Outputs SHALL have no registered state; during and after reset they follow REQ-016 with an empty table, so no stall occurs.
REQ-026 Reset mid-transaction SHALL discard all tracking; responses arriving afterwards follow REQ-022.

Configuration
REQ-027 With macro AXI_ID_COMPRESS_OCCUPANCY_EN defined, SHALL add outputs wr_used_o and rd_used_o, each $clog2(MaxUniqIds+1) bits: number of valid entries, registered, reset 0.
REQ-028 Without AXI_ID_COMPRESS_OCCUPANCY_EN, these ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Defaults; AR id 0x2A, mst ready=1 -> mst ar.id=0; R id 0, last=1 -> slv r.id=0x2A, read entry 0 invalid next cycle.
REQ-030 AW ids 0x01,0x02,0x03,0x04 accepted, no B -> mst ids 0,1,2,3; fifth AW id 0x05 -> stalled, aw_ready=0, until any B handshake frees an entry, then issued with freed index next cycle.
REQ-031 Three AW id 0x11 in a row -> first two issue as id 0, third stalls until B id 0 returns.
REQ-032 Same cycle: new AR id 0x11 (entry 0, counter 1) and R last id 0 -> counter stays 1, entry stays valid, slv r.id=0x11.
REQ-033 Assert rst_ni low with 4 write entries busy -> all entries cleared; next AW id 0x3F issues as id 0; late B id 2 -> slv b.id=0.
REQ-034 Build with AXI_ID_COMPRESS_OCCUPANCY_EN, two ARs to different IDs -> rd_used_o 0 -> 1 -> 2; wr_used_o stays 0.

Source files
------------

// File: rtl/axi_id_compress.sv
// AXI4 ID compressor: remaps wide slave-port IDs onto a small table index on the master port.
// Optional per-direction occupancy outputs are enabled with AXI_ID_COMPRESS_OCCUPANCY_EN.

package axi_id_compress_pkg;
  localparam int unsigned AddrWidth  = 32;
  localparam int unsigned DataWidth  = 32;
  localparam int unsigned UserWidth  = 1;
  localparam int unsigned SlvIdWidth = 6;
  localparam int unsigned MstIdWidth = 2;

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [AddrWidth-1:0]  addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [5:0]            atop;
    logic [UserWidth-1:0]  user;
  } slv_aw_chan_t;

  typedef struct packed {
    logic [MstIdWidth-1:0] id;
    logic [AddrWidth-1:0]  addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [5:0]            atop;
    logic [UserWidth-1:0]  user;
  } mst_aw_chan_t;

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [AddrWidth-1:0]  addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [UserWidth-1:0]  user;
  } slv_ar_chan_t;

  typedef struct packed {
    logic [MstIdWidth-1:0] id;
    logic [AddrWidth-1:0]  addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [UserWidth-1:0]  user;
  } mst_ar_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
    logic [UserWidth-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [1:0]            resp;
    logic [UserWidth-1:0]  user;
  } slv_b_chan_t;

  typedef struct packed {
    logic [MstIdWidth-1:0] id;
    logic [1:0]            resp;
    logic [UserWidth-1:0]  user;
  } mst_b_chan_t;

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [DataWidth-1:0]  data;
    logic [1:0]            resp;
    logic                  last;
    logic [UserWidth-1:0]  user;
  } slv_r_chan_t;

  typedef struct packed {
    logic [MstIdWidth-1:0] id;
    logic [DataWidth-1:0]  data;
    logic [1:0]            resp;
    logic                  last;
    logic [UserWidth-1:0]  user;
  } mst_r_chan_t;

  typedef struct packed {
    slv_aw_chan_t aw;
    logic         aw_valid;
    w_chan_t      w;
    logic         w_valid;
    logic         b_ready;
    slv_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } slv_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    slv_b_chan_t b;
    logic        r_valid;
    slv_r_chan_t r;
  } slv_resp_t;

  typedef struct packed {
    mst_aw_chan_t aw;
    logic         aw_valid;
    w_chan_t      w;
    logic         w_valid;
    logic         b_ready;
    mst_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } mst_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    mst_b_chan_t b;
    logic        r_valid;
    mst_r_chan_t r;
  } mst_resp_t;
endpackage

module axi_id_compress #(
  parameter int unsigned SlvPortIdWidth = 6,
  parameter int unsigned MstPortIdWidth = 2,
  parameter int unsigned MaxUniqIds     = 4,
  parameter int unsigned MaxTxnsPerId   = 2,
  parameter type slv_req_t  = axi_id_compress_pkg::slv_req_t,
  parameter type slv_resp_t = axi_id_compress_pkg::slv_resp_t,
  parameter type mst_req_t  = axi_id_compress_pkg::mst_req_t,
  parameter type mst_resp_t = axi_id_compress_pkg::mst_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  slv_req_t  slv_req_i,
  output slv_resp_t slv_resp_o,
  output mst_req_t  mst_req_o,
  input  mst_resp_t mst_resp_i
`ifdef AXI_ID_COMPRESS_OCCUPANCY_EN
  ,
  output logic [$clog2(MaxUniqIds+1)-1:0] wr_used_o,
  output logic [$clog2(MaxUniqIds+1)-1:0] rd_used_o
`endif
);

  localparam int unsigned IdxW  = (MaxUniqIds > 1) ? $clog2(MaxUniqIds) : 1;
  localparam int unsigned CntW  = $clog2(MaxTxnsPerId + 1);
  localparam int unsigned UsedW = $clog2(MaxUniqIds + 1);
  localparam logic [CntW-1:0]         MaxCnt = CntW'(MaxTxnsPerId);
  localparam logic [MstPortIdWidth:0] NumEnt = (MstPortIdWidth + 1)'(MaxUniqIds);

  // Index 0 is the write direction (AW/B), index 1 the read direction (AR/R).
  logic [1:0]                      req_valid, mst_ready, rsp_fire, rsp_hit;
  logic [1:0]                      stall, alloc_fire, has_match;
  logic [1:0][SlvPortIdWidth-1:0]  req_id, rsp_slv_id;
  logic [1:0][MstPortIdWidth-1:0]  rsp_id;
  logic [1:0][IdxW-1:0]            sel, rsp_idx;

  logic [1:0][MaxUniqIds-1:0]                     valid_q, valid_d;
  logic [1:0][MaxUniqIds-1:0][SlvPortIdWidth-1:0] id_q, id_d;
  logic [1:0][MaxUniqIds-1:0][CntW-1:0]           cnt_q, cnt_d;

  assign req_valid = {slv_req_i.ar_valid, slv_req_i.aw_valid};
  assign req_id    = {slv_req_i.ar.id, slv_req_i.aw.id};
  assign mst_ready = {mst_resp_i.ar_ready, mst_resp_i.aw_ready};
  assign rsp_id    = {mst_resp_i.r.id, mst_resp_i.b.id};
  assign rsp_fire[0] = mst_resp_i.b_valid & slv_req_i.b_ready;
  assign rsp_fire[1] = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

  always_comb begin
    stall      = '1;
    sel        = '0;
    has_match  = '0;
    rsp_idx    = '0;
    rsp_hit    = '0;
    rsp_slv_id = '0;
    alloc_fire = '0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < MaxUniqIds; i++) begin
        if (valid_q[d][i] && (id_q[d][i] == req_id[d])) begin
          has_match[d] = 1'b1;
          // A saturated entry stalls; the same ID never spills into a second entry.
          if (cnt_q[d][i] < MaxCnt) begin
            stall[d] = 1'b0;
            sel[d]   = IdxW'(i);
          end
        end
      end
      if (!has_match[d]) begin
        for (int i = MaxUniqIds - 1; i >= 0; i--) begin
          if (!valid_q[d][i]) begin
            stall[d] = 1'b0;
            sel[d]   = IdxW'(i);
          end
        end
      end
      alloc_fire[d] = req_valid[d] & ~stall[d] & mst_ready[d];
      rsp_idx[d]    = rsp_id[d][IdxW-1:0];
      rsp_hit[d]    = ({1'b0, rsp_id[d]} < NumEnt) && valid_q[d][rsp_idx[d]];
      if (rsp_hit[d]) rsp_slv_id[d] = id_q[d][rsp_idx[d]];
    end
  end

  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < MaxUniqIds; i++) begin
        logic inc, dec;
        inc = alloc_fire[d] && (sel[d] == IdxW'(i));
        dec = rsp_fire[d] && rsp_hit[d] && (rsp_idx[d] == IdxW'(i));
        if (inc && !dec) begin
          valid_d[d][i] = 1'b1;
          id_d[d][i]    = req_id[d];
          cnt_d[d][i]   = cnt_q[d][i] + CntW'(1);
        end else if (dec && !inc) begin
          cnt_d[d][i] = cnt_q[d][i] - CntW'(1);
          if (cnt_q[d][i] == CntW'(1)) valid_d[d][i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef AXI_ID_COMPRESS_OCCUPANCY_EN
  logic [1:0][UsedW-1:0] used_q, used_d;

  always_comb begin
    used_d = '0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < MaxUniqIds; i++) begin
        used_d[d] = used_d[d] + UsedW'(valid_d[d][i]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) used_q <= '0;
    else         used_q <= used_d;
  end

  assign wr_used_o = used_q[0];
  assign rd_used_o = used_q[1];
`endif

  always_comb begin
    mst_req_o           = '0;
    mst_req_o.aw.id     = MstPortIdWidth'(sel[0]);
    mst_req_o.aw.addr   = slv_req_i.aw.addr;
    mst_req_o.aw.len    = slv_req_i.aw.len;
    mst_req_o.aw.size   = slv_req_i.aw.size;
    mst_req_o.aw.burst  = slv_req_i.aw.burst;
    mst_req_o.aw.lock   = slv_req_i.aw.lock;
    mst_req_o.aw.cache  = slv_req_i.aw.cache;
    mst_req_o.aw.prot   = slv_req_i.aw.prot;
    mst_req_o.aw.qos    = slv_req_i.aw.qos;
    mst_req_o.aw.region = slv_req_i.aw.region;
    mst_req_o.aw.atop   = '0;  // atomics are not supported
    mst_req_o.aw.user   = slv_req_i.aw.user;
    mst_req_o.aw_valid  = slv_req_i.aw_valid & ~stall[0];
    mst_req_o.w         = slv_req_i.w;
    mst_req_o.w_valid   = slv_req_i.w_valid;
    mst_req_o.b_ready   = slv_req_i.b_ready;
    mst_req_o.ar.id     = MstPortIdWidth'(sel[1]);
    mst_req_o.ar.addr   = slv_req_i.ar.addr;
    mst_req_o.ar.len    = slv_req_i.ar.len;
    mst_req_o.ar.size   = slv_req_i.ar.size;
    mst_req_o.ar.burst  = slv_req_i.ar.burst;
    mst_req_o.ar.lock   = slv_req_i.ar.lock;
    mst_req_o.ar.cache  = slv_req_i.ar.cache;
    mst_req_o.ar.prot   = slv_req_i.ar.prot;
    mst_req_o.ar.qos    = slv_req_i.ar.qos;
    mst_req_o.ar.region = slv_req_i.ar.region;
    mst_req_o.ar.user   = slv_req_i.ar.user;
    mst_req_o.ar_valid  = slv_req_i.ar_valid & ~stall[1];
    mst_req_o.r_ready   = slv_req_i.r_ready;

    slv_resp_o          = '0;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~stall[0];
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~stall[1];
    slv_resp_o.w_ready  = mst_resp_i.w_ready;
    slv_resp_o.b_valid  = mst_resp_i.b_valid;
    slv_resp_o.b.id     = rsp_slv_id[0];
    slv_resp_o.b.resp   = mst_resp_i.b.resp;
    slv_resp_o.b.user   = mst_resp_i.b.user;
    slv_resp_o.r_valid  = mst_resp_i.r_valid;
    slv_resp_o.r.id     = rsp_slv_id[1];
    slv_resp_o.r.data   = mst_resp_i.r.data;
    slv_resp_o.r.resp   = mst_resp_i.r.resp;
    slv_resp_o.r.last   = mst_resp_i.r.last;
    slv_resp_o.r.user   = mst_resp_i.r.user;
  end

endmodule

// File: tb/tb_axi_id_compress.sv
// Directed bench for axi_id_compress: scoreboarded ID remapping, stalls, reset and response restore.
module tb_axi_id_compress;
  import axi_id_compress_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slv_req_t  slv_req;
  slv_resp_t slv_resp;
  mst_req_t  mst_req;
  mst_resp_t mst_resp;

  int vectors = 0;
  int miscompares = 0;
  logic [1:0] sb_q[$];

`ifdef AXI_ID_COMPRESS_OCCUPANCY_EN
  logic [2:0] wr_used, rd_used;
`endif

  axi_id_compress #(
    .SlvPortIdWidth(6),
    .MstPortIdWidth(2),
    .MaxUniqIds(4),
    .MaxTxnsPerId(2),
    .slv_req_t(slv_req_t),
    .slv_resp_t(slv_resp_t),
    .mst_req_t(mst_req_t),
    .mst_resp_t(mst_resp_t)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .slv_req_i(slv_req),
    .slv_resp_o(slv_resp),
    .mst_req_o(mst_req),
    .mst_resp_i(mst_resp)
`ifdef AXI_ID_COMPRESS_OCCUPANCY_EN
    ,
    .wr_used_o(wr_used),
    .rd_used_o(rd_used)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive an AW (rd=0) or AR (rd=1) and wait a bounded time for the master-side handshake.
  task automatic issue(input bit rd, input logic [5:0] id, input logic [1:0] exp_idx,
                       input string tag);
    bit done;
    logic [1:0] e;
    done = 1'b0;
    sb_q.push_back(exp_idx);
    if (rd) begin
      slv_req.ar.id = id;
      slv_req.ar_valid = 1'b1;
    end else begin
      slv_req.aw.id = id;
      slv_req.aw_valid = 1'b1;
    end
    for (int c = 0; c < 8 && !done; c++) begin
      #3;
      if (rd ? (mst_req.ar_valid && mst_resp.ar_ready) : (mst_req.aw_valid && mst_resp.aw_ready))
      begin
        e = sb_q.pop_front();
        check({tag, "_id"}, rd ? 32'(mst_req.ar.id) : 32'(mst_req.aw.id), 32'(e));
        done = 1'b1;
      end
      cycle();
    end
    slv_req.aw_valid = 1'b0;
    slv_req.ar_valid = 1'b0;
    if (!done) void'(sb_q.pop_front());
    check({tag, "_hs"}, 32'(done), 32'd1);
  endtask

  // One B (rd=0) or R (rd=1) beat; checks the restored slave-side ID.
  task automatic respond(input bit rd, input logic [1:0] idx, input bit last,
                         input logic [5:0] exp_id, input string tag);
    if (rd) begin
      mst_resp.r.id = idx;
      mst_resp.r.last = last;
      mst_resp.r_valid = 1'b1;
    end else begin
      mst_resp.b.id = idx;
      mst_resp.b_valid = 1'b1;
    end
    #3;
    check(tag, rd ? 32'(slv_resp.r.id) : 32'(slv_resp.b.id), 32'(exp_id));
    cycle();
    mst_resp.r_valid = 1'b0;
    mst_resp.b_valid = 1'b0;
  endtask

  initial begin
    slv_req = '0;
    mst_resp = '0;
    mst_resp.aw_ready = 1'b1;
    mst_resp.ar_ready = 1'b1;
    mst_resp.w_ready = 1'b1;
    slv_req.b_ready = 1'b1;
    slv_req.r_ready = 1'b1;

    // During reset: empty table, pure combinational pass-through.
    #1;
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id = 6'h05;
    slv_req.aw.addr = 32'h1234_5678;
    slv_req.aw.atop = 6'h3F;
    slv_req.w.data = 32'hCAFE_F00D;
    slv_req.w_valid = 1'b1;
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id = 2'd1;
    #3;
    check("rst_aw_valid", 32'(mst_req.aw_valid), 32'd1);
    check("rst_aw_ready", 32'(slv_resp.aw_ready), 32'd1);
    check("rst_aw_id", 32'(mst_req.aw.id), 32'd0);
    check("rst_atop", 32'(mst_req.aw.atop), 32'd0);
    check("rst_addr", mst_req.aw.addr, 32'h1234_5678);
    check("w_data", mst_req.w.data, 32'hCAFE_F00D);
    check("w_valid", 32'(mst_req.w_valid), 32'd1);
    check("rst_b_id", 32'(slv_resp.b.id), 32'd0);
    cycle();
    cycle();
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid = 1'b0;
    mst_resp.b_valid = 1'b0;
    rst_n = 1'b1;
    cycle();

    // Single read round trip; the entry frees after the last beat.
    issue(1'b1, 6'h2A, 2'd0, "ar2a");
    respond(1'b1, 2'd0, 1'b1, 6'h2A, "r2a_id");
    respond(1'b1, 2'd0, 1'b1, 6'h00, "r_freed_id");

    // Non-last beats keep the entry alive.
    issue(1'b1, 6'h07, 2'd0, "ar07");
    respond(1'b1, 2'd0, 1'b0, 6'h07, "r07_mid");
    respond(1'b1, 2'd0, 1'b1, 6'h07, "r07_last");
    respond(1'b1, 2'd0, 1'b1, 6'h00, "r07_gone");

    // Fill the write table, then stall a fifth ID until a B frees an entry.
    issue(1'b0, 6'h01, 2'd0, "aw01");
    issue(1'b0, 6'h02, 2'd1, "aw02");
    issue(1'b0, 6'h03, 2'd2, "aw03");
    issue(1'b0, 6'h04, 2'd3, "aw04");
    slv_req.aw.id = 6'h05;
    slv_req.aw_valid = 1'b1;
    #3;
    check("aw05_stall_valid", 32'(mst_req.aw_valid), 32'd0);
    check("aw05_stall_ready", 32'(slv_resp.aw_ready), 32'd0);
    cycle();
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id = 2'd2;
    #3;
    check("b2_id", 32'(slv_resp.b.id), 32'h03);
    check("aw05_same_cycle_ready", 32'(slv_resp.aw_ready), 32'd0);
    cycle();
    mst_resp.b_valid = 1'b0;
    issue(1'b0, 6'h05, 2'd2, "aw05");

    // Reset with a full table discards all tracking.
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    issue(1'b0, 6'h3F, 2'd0, "aw3f");
    respond(1'b0, 2'd2, 1'b0, 6'h00, "b_late_id");
    respond(1'b0, 2'd0, 1'b0, 6'h3F, "b3f_id");

    // Same ID up to MaxTxnsPerId, then stall on the saturated entry.
    issue(1'b0, 6'h11, 2'd0, "aw11_a");
    issue(1'b0, 6'h11, 2'd0, "aw11_b");
    slv_req.aw.id = 6'h11;
    slv_req.aw_valid = 1'b1;
    #3;
    check("aw11_c_stall", 32'(slv_resp.aw_ready), 32'd0);
    cycle();
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id = 2'd0;
    #3;
    check("b11_a_id", 32'(slv_resp.b.id), 32'h11);
    check("aw11_c_still", 32'(mst_req.aw_valid), 32'd0);
    cycle();
    mst_resp.b_valid = 1'b0;
    issue(1'b0, 6'h11, 2'd0, "aw11_c");
    respond(1'b0, 2'd0, 1'b0, 6'h11, "b11_b_id");
    respond(1'b0, 2'd0, 1'b0, 6'h11, "b11_c_id");
    respond(1'b0, 2'd0, 1'b0, 6'h00, "b11_gone");

    // Simultaneous increment and decrement on one read entry.
    issue(1'b1, 6'h11, 2'd0, "ar11");
    slv_req.ar.id = 6'h11;
    slv_req.ar_valid = 1'b1;
    mst_resp.r_valid = 1'b1;
    mst_resp.r.id = 2'd0;
    mst_resp.r.last = 1'b1;
    #3;
    check("ar11_both_valid", 32'(mst_req.ar_valid), 32'd1);
    check("ar11_both_id", 32'(mst_req.ar.id), 32'd0);
    check("r11_both_id", 32'(slv_resp.r.id), 32'h11);
    cycle();
    slv_req.ar_valid = 1'b0;
    mst_resp.r_valid = 1'b0;
    respond(1'b1, 2'd0, 1'b1, 6'h11, "r11_kept");
    respond(1'b1, 2'd0, 1'b1, 6'h00, "r11_gone");

`ifdef AXI_ID_COMPRESS_OCCUPANCY_EN
    check("rd_used_0", 32'(rd_used), 32'd0);
    issue(1'b1, 6'h01, 2'd0, "occ_ar01");
    check("rd_used_1", 32'(rd_used), 32'd1);
    issue(1'b1, 6'h02, 2'd1, "occ_ar02");
    check("rd_used_2", 32'(rd_used), 32'd2);
    check("wr_used_0", 32'(wr_used), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
